// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, state codes, ALU/mux selects.
// Optional build macro MCTRL_MEM_WAIT_EN enables memory wait-state handling.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ST_W    = 4;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned PCSRC_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ST_W-1:0] ST_FETCH    = 4'd0;
  localparam logic [ST_W-1:0] ST_DECODE   = 4'd1;
  localparam logic [ST_W-1:0] ST_MEM_ADDR = 4'd2;
  localparam logic [ST_W-1:0] ST_MEM_RD   = 4'd3;
  localparam logic [ST_W-1:0] ST_MEM_WB   = 4'd4;
  localparam logic [ST_W-1:0] ST_MEM_WR   = 4'd5;
  localparam logic [ST_W-1:0] ST_R_EXE    = 4'd6;
  localparam logic [ST_W-1:0] ST_R_WB     = 4'd7;
  localparam logic [ST_W-1:0] ST_BEQ      = 4'd8;
  localparam logic [ST_W-1:0] ST_JUMP     = 4'd9;
  localparam logic [ST_W-1:0] ST_ORI_EXE  = 4'd10;
  localparam logic [ST_W-1:0] ST_ORI_WB   = 4'd11;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b100;

  localparam logic [SRCB_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_BRANCH = 2'b11;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_TARGET = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic                pc_wr;
    logic                ir_wr;
    logic                i_or_d;
    logic                reg_dst;
    logic                alu_src_a;
    logic                mem_to_reg;
    logic                reg_wr;
    logic                mem_wr;
    logic                mem_rd;
    logic                ext_op;
    logic                done;
    logic [SRCB_W-1:0]   alu_src_b;
    logic [PCSRC_W-1:0]  pc_src;
    logic [ALUOP_W-1:0]  alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // True for the opcodes this controller executes.
  function automatic logic op_decoded(input logic [OP_W-1:0] op);
    return op inside {OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

endpackage

// File: rtl/mctrl_outdec.sv
// Moore output decoder: maps the current state (plus zero for BEQ) to control signals.
// With MCTRL_MEM_WAIT_EN, memory-state strobes are qualified by mem_ready.
module mctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  logic [ST_W-1:0]   i_state,
  input  logic              i_zero,
`ifdef MCTRL_MEM_WAIT_EN
  input  logic              i_mem_ready,
`endif
  output logic [CTRL_W-1:0] o_ctrl_c
);

  ctrl_t w_ctrl;
  logic  w_mem_ok;

`ifdef MCTRL_MEM_WAIT_EN
  assign w_mem_ok = i_mem_ready;
`else
  assign w_mem_ok = 1'b1;
`endif

  always_comb begin
    w_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        w_ctrl.mem_rd    = 1'b1;
        w_ctrl.ir_wr     = w_mem_ok;
        w_ctrl.pc_wr     = w_mem_ok;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_src    = PCSRC_ALU;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_b = SRCB_BRANCH;
        w_ctrl.ext_op    = 1'b1;
      end
      ST_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.ext_op    = 1'b1;
      end
      ST_MEM_RD: begin
        w_ctrl.mem_rd = 1'b1;
        w_ctrl.i_or_d = 1'b1;
      end
      ST_MEM_WB: begin
        w_ctrl.reg_wr     = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.done       = 1'b1;
      end
      ST_MEM_WR: begin
        w_ctrl.mem_wr = w_mem_ok;
        w_ctrl.i_or_d = 1'b1;
        w_ctrl.done   = w_mem_ok;
      end
      ST_R_EXE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        w_ctrl.reg_wr  = 1'b1;
        w_ctrl.reg_dst = 1'b1;
        w_ctrl.done    = 1'b1;
      end
      ST_ORI_EXE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_OR;
      end
      ST_ORI_WB: begin
        w_ctrl.reg_wr = 1'b1;
        w_ctrl.done   = 1'b1;
      end
      // Branch resolves in this cycle; PC is written only when operands compare equal.
      ST_BEQ: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_src    = PCSRC_TARGET;
        w_ctrl.pc_wr     = i_zero;
        w_ctrl.done      = 1'b1;
      end
      ST_JUMP: begin
        w_ctrl.pc_wr  = 1'b1;
        w_ctrl.pc_src = PCSRC_JUMP;
        w_ctrl.done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_ctrl_c = w_ctrl;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: state register, next-state logic, illegal-op flag.
// Build macro MCTRL_MEM_WAIT_EN makes FETCH/MEM_RD/MEM_WR stall until mem_ready.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCWr,
  output logic            IRWr,
  output logic            IorD,
  output logic            RegDst,
  output logic            ALUSrcA,
  output logic            MemtoReg,
  output logic            RegWr,
  output logic            MemWr,
  output logic            MemRd,
  output logic            ExtOp,
  output logic            Done,
  output logic            Illegal,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSrc,
  output logic [2:0]      ALUop,
  output logic [ST_W-1:0] state
);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_next;
  logic              r_illegal;
  logic              w_mem_ok;
  logic [CTRL_W-1:0] w_ctrl_vec;
  ctrl_t             w_ctrl;

`ifdef MCTRL_MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:    w_next = w_mem_ok ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = ST_MEM_ADDR;
          OP_RTYPE:     w_next = ST_R_EXE;
          OP_ORI:       w_next = ST_ORI_EXE;
          OP_BEQ:       w_next = ST_BEQ;
          OP_J:         w_next = ST_JUMP;
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: begin
        if (op == OP_LW)      w_next = ST_MEM_RD;
        else if (op == OP_SW) w_next = ST_MEM_WR;
        else                  w_next = ST_FETCH;
      end
      ST_MEM_RD:   w_next = w_mem_ok ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WR:   w_next = w_mem_ok ? ST_FETCH : ST_MEM_WR;
      ST_R_EXE:    w_next = ST_R_WB;
      ST_ORI_EXE:  w_next = ST_ORI_WB;
      default:     w_next = ST_FETCH;
    endcase
  end

  mctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_zero      (zero),
`ifdef MCTRL_MEM_WAIT_EN
    .i_mem_ready (mem_ready),
`endif
    .o_ctrl_c    (w_ctrl_vec)
  );

  // One-cycle flag in the cycle after an undecoded opcode leaves DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else        r_illegal <= (r_state == ST_DECODE) && !op_decoded(op);
  end

  assign w_ctrl = ctrl_t'(w_ctrl_vec);

  // Write strobes are suppressed while reset is held, even though state reads FETCH.
  assign PCWr     = w_ctrl.pc_wr  & rst_n;
  assign IRWr     = w_ctrl.ir_wr  & rst_n;
  assign RegWr    = w_ctrl.reg_wr & rst_n;
  assign MemWr    = w_ctrl.mem_wr & rst_n;
  assign IorD     = w_ctrl.i_or_d;
  assign RegDst   = w_ctrl.reg_dst;
  assign ALUSrcA  = w_ctrl.alu_src_a;
  assign MemtoReg = w_ctrl.mem_to_reg;
  assign MemRd    = w_ctrl.mem_rd;
  assign ExtOp    = w_ctrl.ext_op;
  assign Done     = w_ctrl.done;
  assign ALUSrcB  = w_ctrl.alu_src_b;
  assign PCSrc    = w_ctrl.pc_src;
  assign ALUop    = w_ctrl.alu_op;
  assign Illegal  = r_illegal;
  assign state    = r_state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port op, input, 6 bits: opcode field of the instruction register.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory access completes in this cycle.
REQ-006 SHALL have ports PCWr, IRWr, IorD, RegDst, ALUSrcA, MemtoReg, RegWr, MemWr, MemRd, ExtOp, Done, Illegal, each an output of 1 bit.
REQ-007 SHALL have ports ALUSrcB and PCSrc, each an output of 2 bits, and ALUop, an output of 3 bits.
REQ-008 SHALL have port state, output, 4 bits: current state code, for debug.

Function
REQ-009 SHALL decode these opcodes: R-type 000000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
REQ-010 SHALL use these state codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BEQ=8, JUMP=9, ORI_EXE=10, ORI_WB=11; codes 12-15 SHALL go to FETCH on the next clock.
REQ-011 SHALL use these transitions: FETCH->DECODE; DECODE->MEM_ADDR for lw or sw; DECODE->R_EXE for R-type; DECODE->ORI_EXE for ori; DECODE->BEQ for beq; DECODE->JUMP for j; DECODE->FETCH for any other opcode.
REQ-012 SHALL use these further transitions: MEM_ADDR->MEM_RD for lw, ->MEM_WR for sw; MEM_RD->MEM_WB; R_EXE->R_WB; ORI_EXE->ORI_WB; MEM_WB, MEM_WR, R_WB, ORI_WB, BEQ and JUMP ->FETCH.
REQ-013 SHALL drive each output from the current state only (Moore), except PCWr in BEQ, which SHALL equal zero.
REQ-014 Every output not listed for a state SHALL be 0 in that state.
REQ-015 In FETCH: MemRd=1, IorD=0, IRWr=1, PCWr=1, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSrc=00.
REQ-016 In DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUop=000 (branch target into ALUOut).
REQ-017 In MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUop=000.
REQ-018 In MEM_RD: MemRd=1, IorD=1. In MEM_WR: MemWr=1, IorD=1, Done=1.
REQ-019 In MEM_WB: RegWr=1, MemtoReg=1, RegDst=0, Done=1.
REQ-020 In R_EXE: ALUSrcA=1, ALUSrcB=00, ALUop=001. In R_WB: RegWr=1, RegDst=1, MemtoReg=0, Done=1.
REQ-021 In ORI_EXE: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUop=010. In ORI_WB: RegWr=1, RegDst=0, MemtoReg=0, Done=1.
REQ-022 In BEQ: ALUSrcA=1, ALUSrcB=00, ALUop=100, PCSrc=01, Done=1. In JUMP: PCWr=1, PCSrc=10, Done=1.
REQ-023 Illegal SHALL pulse high for exactly one cycle, on the cycle after DECODE, for an undecoded opcode; no write strobe SHALL assert for that instruction.
REQ-024 Latencies SHALL be (no memory wait): lw 5 cycles, sw/R/ori 4 cycles, beq/j 3 cycles, FETCH to FETCH.

Reset
REQ-025 While rst_n=0, state SHALL be FETCH immediately (asynchronously), and Illegal SHALL be 0.
REQ-026 Write strobes (PCWr, IRWr, RegWr, MemWr) SHALL be forced to 0 while rst_n=0.
REQ-027 After rst_n deasserts, the first rising edge SHALL begin a fresh FETCH.
REQ-028 A reset asserted mid-instruction SHALL abandon that instruction without any further write strobe.

Configuration
REQ-029 With MCTRL_MEM_WAIT_EN defined, FETCH, MEM_RD and MEM_WR SHALL hold state while mem_ready=0.
REQ-030 With MCTRL_MEM_WAIT_EN defined, IRWr, PCWr and MemWr in those states SHALL assert only in the cycle mem_ready=1, and Done in MEM_WR SHALL likewise be gated by mem_ready.
REQ-031 Without MCTRL_MEM_WAIT_EN, mem_ready SHALL be ignored and every memory state SHALL last one cycle.

Structure
REQ-032 A shared package SHALL hold the opcode constants, state codes, and ALUop, ALUSrcB and PCSrc encodings.
REQ-033 A sub-module mctrl_outdec SHALL map state (and zero, plus mem_ready when configured) to outputs; the top SHALL hold the state register and next-state logic.

Verification
REQ-034 Reset test: hold rst_n=0, then release -> state=0 asynchronously; first cycle after release shows IRWr=1, PCWr=1, ALUSrcB=01.
REQ-035 lw test: op=100011 -> states 0,1,2,3,4; RegWr=1 and MemtoReg=1 only in state 4; Done=1 only in state 4.
REQ-036 beq test: op=000100 with zero=1 -> PCWr=1 and PCSrc=01 in state 8; with zero=0 -> PCWr=0; returns to FETCH after 3 cycles.
REQ-037 Illegal-opcode test: op=111111 -> DECODE->FETCH, Illegal=1 for one cycle, RegWr=0 and MemWr=0 throughout.
REQ-038 Memory-wait test (MCTRL_MEM_WAIT_EN): sw with mem_ready=0 for 3 cycles in MEM_WR -> state holds at 5, MemWr=0, then MemWr=1 for one cycle when mem_ready=1.
REQ-039 Mid-instruction reset test: assert rst_n=0 in R_EXE -> state=0 with no RegWr pulse.
